// File: rtl/wb_queue_stage.sv
// Writeback queue: buffers register-file writes between execute/memory and the RF.
// Head entry is presented registered; a lookup port forwards the youngest pending write.
module wb_queue_stage #(
   parameter int WORD_LENGTH = 32,
   parameter int DEST_WIDTH  = 4,
   parameter int DEPTH       = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_enable_in,
   input  logic                     mem_read_enable,
   input  logic [WORD_LENGTH-1:0]   alu_result,
   input  logic [WORD_LENGTH-1:0]   data_memory,
   input  logic [DEST_WIDTH-1:0]    wb_dest_in,
   output logic                     in_ready,
   input  logic                     rf_ready,
   output logic                     wb_enable_out,
   output logic [DEST_WIDTH-1:0]    wb_dest_out,
   output logic [WORD_LENGTH-1:0]   wb_value,
   input  logic [DEST_WIDTH-1:0]    lookup_addr,
   output logic                     lookup_hit,
   output logic [WORD_LENGTH-1:0]   lookup_value,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEST_WIDTH-1:0]  dest_q [DEPTH];
   logic [WORD_LENGTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]       valid_q;
   logic [PW-1:0]          head;
   logic [PW-1:0]          tail;
   logic [CW-1:0]          cnt;
   logic                   push;
   logic                   pop;
   logic [WORD_LENGTH-1:0] sel_value;
   logic [PW-1:0]          idx;

   assign in_ready      = (cnt != CW'(DEPTH));
   assign wb_enable_out = (cnt != '0);
   assign push          = wb_enable_in && in_ready;
   assign pop           = wb_enable_out && rf_ready;
   assign sel_value     = mem_read_enable ? data_memory : alu_result;
   assign count         = cnt;

   assign wb_dest_out = wb_enable_out ? dest_q[head] : '0;
   assign wb_value    = wb_enable_out ? data_q[head] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         cnt     <= '0;
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dest_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         // pop before push: when neither full nor empty, head and tail differ
         if (pop) begin
            valid_q[head] <= 1'b0;
            head          <= head + PW'(1);
         end
         if (push) begin
            dest_q[tail]  <= wb_dest_in;
            data_q[tail]  <= sel_value;
            valid_q[tail] <= 1'b1;
            tail          <= tail + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // scan oldest to youngest so the last match is the most recent write
   always_comb begin
      lookup_hit   = 1'b0;
      lookup_value = '0;
      idx          = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (valid_q[idx] && dest_q[idx] == lookup_addr) begin
            lookup_hit   = 1'b1;
            lookup_value = data_q[idx];
         end
      end
   end

endmodule

// File: doc/wb_queue_stage.md
WB_QUEUE_STAGE -- requirements
Module: wb_queue_stage

Interface
REQ-001 Parameter WORD_LENGTH, default 32: width of writeback data.
REQ-002 Parameter DEST_WIDTH, default 4: width of register-file destination address.
REQ-003 Parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 wb_enable_in  input  1  writeback request valid this cycle.
REQ-007 mem_read_enable  input  1  source select: 1 = data_memory, 0 = alu_result.
REQ-008 alu_result  input  WORD_LENGTH  ALU result.
REQ-009 data_memory  input  WORD_LENGTH  load data.
REQ-010 wb_dest_in  input  DEST_WIDTH  destination register of the request.
REQ-011 in_ready  output  1  queue can accept a request this cycle.
REQ-012 rf_ready  input  1  register file accepts the head write this cycle.
REQ-013 wb_enable_out  output  1  head entry valid, write requested.
REQ-014 wb_dest_out  output  DEST_WIDTH  head entry destination.
REQ-015 wb_value  output  WORD_LENGTH  head entry value.
REQ-016 lookup_addr  input  DEST_WIDTH  register address for the pending-write query.
REQ-017 lookup_hit  output  1  a queued entry targets lookup_addr.
REQ-018 lookup_value  output  WORD_LENGTH  value of the youngest matching entry.
REQ-019 count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-020 Selected value SHALL be data_memory when mem_read_enable=1, else alu_result; selection happens at enqueue.
REQ-021 in_ready SHALL equal (count != DEPTH), derived from registered state only; no combinational path from rf_ready.
REQ-022 Push: wb_enable_in=1 and in_ready=1 at a rising edge SHALL write {wb_dest_in, selected value} at the tail and advance the tail pointer.
REQ-023 wb_enable_in=1 with in_ready=0 SHALL be ignored; the upstream holds the request.
REQ-024 wb_enable_out SHALL equal (count != 0); wb_dest_out and wb_value SHALL show the head entry, and both SHALL be 0 when empty.
REQ-025 Pop: wb_enable_out=1 and rf_ready=1 at a rising edge SHALL retire the head and advance the head pointer.
REQ-026 Latency: a pushed entry SHALL appear at the outputs no earlier than the cycle after its push edge; there is no bypass from input to output.
REQ-027 Push and pop on the same edge SHALL leave count unchanged; a push alone increments count; a pop alone decrements it.
REQ-028 When full, no push occurs even if a pop happens on the same edge; in_ready rises the cycle after the pop.
REQ-029 Head and tail pointers SHALL wrap modulo DEPTH; FIFO order SHALL be preserved across the wrap.
REQ-030 lookup_hit/lookup_value SHALL be combinational over valid entries only, including the head being popped this cycle and excluding the request currently at the input.
REQ-031 With multiple matches, lookup_value SHALL come from the most recently pushed match; on a miss it SHALL be 0.
REQ-032 Request ordering SHALL be pure FIFO, regardless of whether the source is memory or ALU.

Reset
REQ-033 rst=1 SHALL immediately clear count, pointers, entry valid bits and stored data; wb_enable_out=0, wb_dest_out=0, wb_value=0, lookup_hit=0, lookup_value=0, in_ready=1.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries; no write is presented after release until a new push.

Verification
REQ-035 Single push: alu_result=0x11, mem_read_enable=0, dest=3 -> next cycle wb_enable_out=1, dest 3, value 0x11, count=1; rf_ready=1 -> empty the following cycle.
REQ-036 Source select: data_memory=0xAA, alu_result=0x55, mem_read_enable=1 -> queued value 0xAA.
REQ-037 Fill with rf_ready=0: push 4 entries (dest 1..4) -> count=4, in_ready=0; a fifth request is ignored; drain -> order 1,2,3,4.
REQ-038 Simultaneous push/pop at count=2, repeated 6 times -> count stays 2, pointers wrap, outputs remain in FIFO order.
REQ-039 Lookup: queue dest 5=0x10, then dest 5=0x20; lookup_addr=5 -> hit=1, value 0x20; lookup_addr=6 -> hit=0, value 0.
REQ-040 Asynchronous rst pulse mid-cycle with count=3 -> outputs zero before the next edge, count=0, in_ready=1.
